hazard_unit: RTL

Parametrised pipeline hazard controller for the 5-stage core, sitting beside the IF/ID/EX/MEM/WB pipeline registers and driving their per-stage stall and nop controls. It keeps its own scoreboard of in-flight destination registers, so stages only report what the decoded instruction reads and writes. It adds an optional forwarding mode with load-use interlock, a memory-wait state machine that defers branch flushes arriving mid-stall, a memory-wait timeout flag, and stall/bubble performance counters.

---
 rtl/hazard_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/nop/forwarding controller for the 5-stage core.
// Tracks in-flight destinations in a private scoreboard, defers branch
// flushes that arrive during a memory wait, and keeps stall/bubble counters.
module hazard_unit #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned HAZ_DEPTH = 3,
  parameter int unsigned FWD_EN    = 0,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              branch_PC_contral,
  input  logic              iready_n,
  input  logic              dready_n,
  input  logic              dbusy,
  input  logic [1:0]        MemRW_mem,
  output logic              stall_IF,
  output logic              stall_ID,
  output logic              stall_EX,
  output logic              stall_Mem,
  output logic              stall_WB,
  output logic              nop_IF,
  output logic              nop_ID,
  output logic              nop_EX,
  output logic              nop_Mem,
  output logic              nop_WB,
  output logic [2:0]        fwd_sel_rs1,
  output logic [2:0]        fwd_sel_rs2,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  bubble_cycles
);

  localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [HAZ_DEPTH-1:0]   sb_valid_q, sb_valid_d;
  logic [HAZ_DEPTH-1:0]   sb_load_q, sb_load_d;
  logic [REG_AW-1:0]      sb_rd_q [HAZ_DEPTH];
  logic [REG_AW-1:0]      sb_rd_d [HAZ_DEPTH];
  logic                   pending_q, pending_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                   timeout_q, timeout_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]       bubble_cnt_q, bubble_cnt_d;

  logic                   mem_wait;
  logic                   flush;
  logic                   hazard_raw;
  logic                   hazard;
  logic [HAZ_DEPTH-1:0]   match1, match2;
  logic [2:0]             near1, near2;

  assign mem_wait = iready_n | (dready_n & MemRW_mem[1]) | (dbusy & MemRW_mem[0]);
  // A deferred flush fires only on the cycle the wait releases.
  assign flush    = ~mem_wait &
                    (branch_PC_contral | ((state_q == ST_MEM_WAIT) & pending_q));
  assign hazard   = ~mem_wait & ~flush & hazard_raw;

  assign mem_timeout   = timeout_q;
  assign stall_cycles  = stall_cnt_q;
  assign bubble_cycles = bubble_cnt_q;

  // Source/scoreboard matches, nearest producer and raw hazard detection.
  always_comb begin
    match1 = '0;
    match2 = '0;
    near1  = '0;
    near2  = '0;
    for (int k = 0; k < HAZ_DEPTH; k++) begin
      match1[k] = id_use_rs1 & sb_valid_q[k] & (sb_rd_q[k] == id_rs1);
      match2[k] = id_use_rs2 & sb_valid_q[k] & (sb_rd_q[k] == id_rs2);
    end
    for (int k = HAZ_DEPTH - 1; k >= 0; k--) begin
      if (match1[k]) near1 = 3'(k + 1);
      if (match2[k]) near2 = 3'(k + 1);
    end
    if (FWD_EN != 0) hazard_raw = (match1[0] | match2[0]) & sb_load_q[0];
    else             hazard_raw = (|match1) | (|match2);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (mem_wait)  state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!mem_wait) state_d = ST_RUN;
      default:                    state_d = ST_RUN;
    endcase
  end

  // Stage controls: rst > memory wait > flush > data hazard.
  always_comb begin
    stall_IF    = 1'b0;
    stall_ID    = 1'b0;
    stall_EX    = 1'b0;
    stall_Mem   = 1'b0;
    stall_WB    = 1'b0;
    nop_IF      = 1'b0;
    nop_ID      = 1'b0;
    nop_EX      = 1'b0;
    nop_Mem     = 1'b0;
    nop_WB      = 1'b0;
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
    if (rst) begin
      nop_IF = 1'b1;
      nop_ID = 1'b1;
      nop_EX = 1'b1;
    end else begin
      if (mem_wait) begin
        stall_IF  = 1'b1;
        stall_ID  = 1'b1;
        stall_EX  = 1'b1;
        stall_Mem = 1'b1;
        nop_WB    = 1'b1;
      end else if (flush) begin
        nop_IF = 1'b1;
        nop_ID = 1'b1;
        nop_EX = 1'b1;
      end else if (hazard) begin
        stall_IF = 1'b1;
        stall_ID = 1'b1;
        nop_EX   = 1'b1;
      end
      if ((FWD_EN != 0) && !hazard_raw) begin
        fwd_sel_rs1 = near1;
        fwd_sel_rs2 = near2;
      end
    end
  end

  // Scoreboard shift, deferred flush, wait timer and counters.
  always_comb begin
    sb_valid_d   = sb_valid_q;
    sb_load_d    = sb_load_q;
    sb_rd_d      = sb_rd_q;
    pending_d    = pending_q;
    wait_cnt_d   = '0;
    timeout_d    = timeout_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!mem_wait) begin
      for (int k = 1; k < HAZ_DEPTH; k++) begin
        sb_valid_d[k] = sb_valid_q[k-1];
        sb_load_d[k]  = sb_load_q[k-1];
        sb_rd_d[k]    = sb_rd_q[k-1];
      end
      sb_valid_d[0] = id_valid & id_regwrite & (id_rd != '0) & ~hazard & ~flush;
      sb_load_d[0]  = id_is_load;
      sb_rd_d[0]    = id_rd;
    end
    if (flush)                              pending_d = 1'b0;
    else if (mem_wait && branch_PC_contral) pending_d = 1'b1;
    if (mem_wait) begin
      wait_cnt_d = (wait_cnt_q == WAIT_W'(TIMEOUT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (wait_cnt_d == WAIT_W'(TIMEOUT)) timeout_d = 1'b1;
    if (hazard && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  // Registered state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid_q   <= '0;
      sb_load_q    <= '0;
      for (int k = 0; k < HAZ_DEPTH; k++) sb_rd_q[k] <= '0;
      pending_q    <= 1'b0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      sb_valid_q   <= sb_valid_d;
      sb_load_q    <= sb_load_d;
      sb_rd_q      <= sb_rd_d;
      pending_q    <= pending_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule
